// File: rtl/nttn_sequencer.sv
// Command-driven sequencer for the NTTN serial interface: streams twiddle or polynomial
// words from a source RAM, pulses load/start, then captures the result burst into a result RAM.
module nttn_sequencer #(
    parameter int DATA_W    = 32,
    parameter int RING_SIZE = 1024,
    parameter int TW_WORDS  = 2082,
    parameter int ADDR_W    = 12,
    parameter int GAP       = 5,
    parameter int TIMEOUT   = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    output logic              cmd_done,
    output logic              cmd_err,
    output logic              busy,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_wdata,
    output logic              nttn_load_w,
    output logic              nttn_load_data,
    output logic              nttn_start,
    output logic              nttn_start_intt,
    output logic [DATA_W-1:0] nttn_din,
    input  logic              nttn_done,
    input  logic [DATA_W-1:0] nttn_dout
);

    localparam int CMAX0 = (TW_WORDS > RING_SIZE) ? TW_WORDS : RING_SIZE;
    localparam int CMAX1 = (CMAX0 > TIMEOUT) ? CMAX0 : TIMEOUT;
    localparam int CMAX  = (CMAX1 > GAP) ? CMAX1 : GAP;
    localparam int CNT_W = $clog2(CMAX + 1);

    localparam logic [CNT_W-1:0] TW_C   = CNT_W'(TW_WORDS);
    localparam logic [CNT_W-1:0] RING_C = CNT_W'(RING_SIZE);
    localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    localparam logic [1:0] OP_TW   = 2'd0;
    localparam logic [1:0] OP_NTT  = 2'd1;
    localparam logic [1:0] OP_INTT = 2'd2;
    localparam logic [1:0] OP_RSV  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_PULSE, S_STREAM, S_GAP, S_START, S_WAIT, S_CAPTURE, S_FINISH
    } state_t;

    state_t             state_q;
    logic [1:0]         op_q;
    logic [ADDR_W-1:0]  base_q;
    logic               tw_loaded_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               rd_vld_q;
    logic [DATA_W-1:0]  din_hold_q;
    logic [DATA_W-1:0]  din_hold_d;
    logic [CNT_W-1:0]   n_words;

    logic               cmd_ready_q, cmd_done_q, cmd_err_q, busy_q;
    logic               mem_rd_q, res_we_q;
    logic [ADDR_W-1:0]  mem_addr_q, res_addr_q;
    logic               load_w_q, load_data_q, start_q, start_intt_q;

    assign n_words = (op_q == OP_TW) ? TW_C : RING_C;

    // RAM data lands one cycle after the read; pass it straight through that cycle, hold it after.
    assign din_hold_d = rd_vld_q ? mem_rdata : din_hold_q;
    assign nttn_din   = din_hold_d;
    assign res_wdata  = res_we_q ? nttn_dout : '0;

    assign cmd_ready       = cmd_ready_q;
    assign cmd_done        = cmd_done_q;
    assign cmd_err         = cmd_err_q;
    assign busy            = busy_q;
    assign mem_rd          = mem_rd_q;
    assign mem_addr        = mem_addr_q;
    assign res_we          = res_we_q;
    assign res_addr        = res_addr_q;
    assign nttn_load_w     = load_w_q;
    assign nttn_load_data  = load_data_q;
    assign nttn_start      = start_q;
    assign nttn_start_intt = start_intt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_q   <= 1'b0;
            din_hold_q <= '0;
        end else begin
            rd_vld_q   <= mem_rd_q;
            din_hold_q <= din_hold_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= OP_TW;
            base_q       <= '0;
            tw_loaded_q  <= 1'b0;
            cnt_q        <= '0;
            cmd_ready_q  <= 1'b1;
            cmd_done_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            res_we_q     <= 1'b0;
            res_addr_q   <= '0;
            load_w_q     <= 1'b0;
            load_data_q  <= 1'b0;
            start_q      <= 1'b0;
            start_intt_q <= 1'b0;
        end else begin
            cmd_done_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
            load_w_q     <= 1'b0;
            load_data_q  <= 1'b0;
            start_q      <= 1'b0;
            start_intt_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        op_q        <= cmd_op;
                        base_q      <= cmd_base;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_op == OP_RSV || (cmd_op != OP_TW && !tw_loaded_q)) begin
                            state_q    <= S_FINISH;
                            cmd_done_q <= 1'b1;
                            cmd_err_q  <= 1'b1;
                        end else begin
                            state_q     <= S_PULSE;
                            load_w_q    <= (cmd_op == OP_TW);
                            load_data_q <= (cmd_op != OP_TW);
                            mem_rd_q    <= 1'b1;
                            mem_addr_q  <= cmd_base;
                            cnt_q       <= ONE_C;
                        end
                    end
                end
                S_PULSE, S_STREAM: begin
                    // cnt_q counts reads issued; the cycle with no read is the last word on din.
                    if (state_q == S_STREAM && !mem_rd_q) begin
                        state_q <= S_GAP;
                        cnt_q   <= ONE_C;
                    end else begin
                        state_q <= S_STREAM;
                        if (cnt_q < n_words) begin
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= mem_addr_q + ADDR_W'(1);
                            cnt_q      <= cnt_q + ONE_C;
                        end else begin
                            mem_rd_q <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_q >= GAP_C) begin
                        if (op_q == OP_TW) begin
                            state_q    <= S_FINISH;
                            cmd_done_q <= 1'b1;
                        end else begin
                            state_q      <= S_START;
                            start_q      <= (op_q == OP_NTT);
                            start_intt_q <= (op_q == OP_INTT);
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE_C;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT;
                    cnt_q   <= ONE_C;
                end
                S_WAIT: begin
                    if (nttn_done) begin
                        state_q    <= S_CAPTURE;
                        res_we_q   <= 1'b1;
                        res_addr_q <= base_q;
                        cnt_q      <= ONE_C;
                    end else if (cnt_q >= TMO_C) begin
                        state_q    <= S_FINISH;
                        cmd_done_q <= 1'b1;
                        cmd_err_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE_C;
                    end
                end
                S_CAPTURE: begin
                    if (cnt_q >= RING_C) begin
                        res_we_q   <= 1'b0;
                        state_q    <= S_FINISH;
                        cmd_done_q <= 1'b1;
                    end else begin
                        res_addr_q <= res_addr_q + ADDR_W'(1);
                        cnt_q      <= cnt_q + ONE_C;
                    end
                end
                S_FINISH: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    if (op_q == OP_TW) tw_loaded_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nttn_sequencer.sv
// Scoreboard bench for nttn_sequencer: RAM and NTTN behavioural models, expected din words,
// result writes and completions queued at command issue and popped as the DUT produces them.
module tb_nttn_sequencer;
    localparam int DW = 32, RS = 1024, TW = 2082, AW = 12, GP = 5, TMO = 3500, DLAT = 3000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = '0;
    logic [AW-1:0] cmd_base = '0;
    logic          cmd_ready, cmd_done, cmd_err, busy, mem_rd, res_we;
    logic [AW-1:0] mem_addr, res_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] res_wdata, nttn_din, nttn_dout;
    logic          nttn_load_w, nttn_load_data, nttn_start, nttn_start_intt, nttn_done;

    nttn_sequencer #(.DATA_W(DW), .RING_SIZE(RS), .TW_WORDS(TW), .ADDR_W(AW), .GAP(GP),
                     .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_base(cmd_base), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata),
        .nttn_load_w(nttn_load_w), .nttn_load_data(nttn_load_data),
        .nttn_start(nttn_start), .nttn_start_intt(nttn_start_intt),
        .nttn_din(nttn_din), .nttn_done(nttn_done), .nttn_dout(nttn_dout));

    logic [DW-1:0] ram [1<<AW];
    always @(posedge clk) if (mem_rd) mem_rdata <= ram[mem_addr];

    // NTTN model: done DLAT cycles after a start pulse, then dout = m+7 for m = 0..RS-1.
    int ncnt;
    bit model_en = 1'b1;
    always @(posedge clk or posedge reset) begin
        if (reset) ncnt <= 0;
        else if (nttn_start || nttn_start_intt) ncnt <= 1;
        else if (ncnt > 0 && ncnt < DLAT + RS + 10) ncnt <= ncnt + 1;
        else ncnt <= 0;
    end
    assign nttn_done = model_en && (ncnt == DLAT);
    assign nttn_dout = (model_en && ncnt > DLAT && ncnt <= DLAT + RS) ? DW'(ncnt - DLAT - 1 + 7) : '0;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } res_t;
    typedef struct { bit err; int kind; } done_t;
    logic [DW-1:0] din_q[$];
    res_t          res_q[$];
    done_t         done_q[$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int stream_rem = 0, words_seen = 0, last_word_cyc = 0, start_cyc = 0, last_res_cyc = 0;
    int acc_cyc = 0, done_cnt = 0, act_cnt = 0, res_cnt = 0;
    logic [AW-1:0] exp_base = '0;
    bit exp_intt = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (!reset && cmd_valid && cmd_ready) acc_cyc <= cyc;

    always @(negedge clk) begin
        logic [3:0] pulses;
        done_t e;
        res_t r;
        if (!reset) begin
            pulses = {nttn_load_w, nttn_load_data, nttn_start, nttn_start_intt};
            if (mem_rd || res_we || pulses != 0) act_cnt++;
            if (pulses != 0) chk("pulse_onehot", 64'($countones(pulses)), 1);
            if (nttn_load_w || nttn_load_data) begin
                chk("pulse_rd", mem_rd, 1);
                chk("pulse_addr", mem_addr, exp_base);
                stream_rem = nttn_load_w ? TW : RS;
                words_seen = 0;
            end else if (stream_rem > 0) begin
                if (din_q.size() == 0) chk("din_unexp", 1, 0);
                else chk("din", nttn_din, din_q.pop_front());
                stream_rem--;
                words_seen++;
                if (stream_rem == 0) last_word_cyc = cyc;
            end
            if (nttn_start || nttn_start_intt) begin
                start_cyc = cyc;
                chk("start_gap", 64'(cyc - last_word_cyc), GP + 1);
                chk("start_kind", nttn_start_intt, exp_intt);
            end
            if (res_we) begin
                res_cnt++;
                last_res_cyc = cyc;
                if (res_q.size() == 0) chk("res_unexp", 1, 0);
                else begin
                    r = res_q.pop_front();
                    chk("res_addr", res_addr, r.a);
                    chk("res_data", res_wdata, r.d);
                end
            end
            if (cmd_err && !cmd_done) chk("err_alone", 1, 0);
            if (cmd_done) begin
                done_cnt++;
                if (done_q.size() == 0) chk("done_unexp", 1, 0);
                else begin
                    e = done_q.pop_front();
                    chk("done_err", cmd_err, e.err);
                    case (e.kind)
                        0: chk("done_lat_acc", 64'(cyc - acc_cyc), 1);
                        1: chk("done_lat_gap", 64'(cyc - last_word_cyc), GP + 1);
                        2: chk("done_lat_tmo", 64'(cyc - start_cyc), TMO);
                        default: chk("done_lat_cap", 64'(cyc - last_res_cyc), 1);
                    endcase
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // kind: 0 immediate error, 1 LOAD_TW, 2 stream then timeout, 3 full NTT/INTT with results
    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] base, input int kind,
                           input bit err, input bit wait_done);
        int n, t, d0;
        if (kind != 0) begin
            n = (op == 2'd0) ? TW : RS;
            for (int k = 0; k < n; k++) din_q.push_back(ram[AW'(int'(base) + k)]);
        end
        if (kind == 3)
            for (int m = 0; m < RS; m++) res_q.push_back('{a: AW'(int'(base) + m), d: DW'(m + 7)});
        done_q.push_back('{err: err, kind: kind});
        exp_base = base;
        exp_intt = (op == 2'd2);
        t = 0;
        while (!cmd_ready && t < 100) begin tick(); t++; end
        chk("ready_before_cmd", cmd_ready, 1);
        d0 = done_cnt;
        cmd_op = op;
        cmd_base = base;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        if (wait_done) begin
            t = 0;
            while (done_cnt == d0 && t < 20000) begin tick(); t++; end
            chk("done_count", 64'(done_cnt - d0), 1);
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", {cmd_done, cmd_err}, 0);
        chk("rst_mem", {mem_rd, mem_addr}, 0);
        chk("rst_res", {res_we, res_addr}, 0);
        chk("rst_wdata", res_wdata, 0);
        chk("rst_pulses", {nttn_load_w, nttn_load_data, nttn_start, nttn_start_intt}, 0);
        chk("rst_din", nttn_din, 0);
    endtask

    initial begin
        int a0, r0, d0, t;
        for (int k = 0; k < (1 << AW); k++) ram[k] = DW'(k);
        tick(); tick();
        chk_reset_outs();
        reset = 1'b0;
        tick();

        a0 = act_cnt;
        run_cmd(2'd1, 12'h000, 0, 1'b1, 1'b1);
        chk("noload_quiet", 64'(act_cnt - a0), 0);

        run_cmd(2'd0, 12'h000, 1, 1'b0, 1'b1);
        tick();
        chk("ready_after_load", cmd_ready, 1);

        a0 = act_cnt;
        run_cmd(2'd3, 12'h010, 0, 1'b1, 1'b1);
        chk("rsv_quiet", 64'(act_cnt - a0), 0);

        r0 = res_cnt;
        run_cmd(2'd1, 12'h100, 3, 1'b0, 1'b1);
        chk("ntt_nres", 64'(res_cnt - r0), RS);

        r0 = res_cnt;
        run_cmd(2'd2, 12'hF00, 3, 1'b0, 1'b1);
        chk("intt_nres", 64'(res_cnt - r0), RS);

        model_en = 1'b0;
        r0 = res_cnt;
        run_cmd(2'd1, 12'h200, 2, 1'b1, 1'b1);
        chk("tmo_nres", 64'(res_cnt - r0), 0);
        model_en = 1'b1;

        run_cmd(2'd0, 12'h000, 1, 1'b0, 1'b0);
        t = 0;
        while (words_seen < 500 && t < 5000) begin tick(); t++; end
        chk("reach_word500", 64'(words_seen), 500);
        reset = 1'b1;
        #1;
        chk_reset_outs();
        din_q.delete();
        done_q.delete();
        stream_rem = 0;
        d0 = done_cnt;
        tick(); tick(); tick();
        reset = 1'b0;
        tick(); tick();
        chk("rst_no_done", 64'(done_cnt - d0), 0);

        a0 = act_cnt;
        run_cmd(2'd1, 12'h000, 0, 1'b1, 1'b1);
        chk("rst_clears_tw", 64'(act_cnt - a0), 0);
        run_cmd(2'd0, 12'h000, 1, 1'b0, 1'b1);
        tick();
        chk("final_ready", cmd_ready, 1);
        chk("final_din_empty", 64'(din_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
